// File: rtl/id_ex_pkg.sv
// Shared constants for the ID->EX stage: ALU/memory op encodings and the
// field values loaded into the pipeline register when a bubble is inserted.
package id_ex_pkg;
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] MEM_LW  = 4'b0010;

   localparam logic [3:0] ID_EX_BUBBLE_ALU_OP = ALU_ADD;
   localparam logic [3:0] ID_EX_BUBBLE_MEM_OP = MEM_LW;
   localparam logic [1:0] ID_EX_BUBBLE_SEL    = 2'b00;
   localparam logic [4:0] ID_EX_BUBBLE_REG    = 5'd0;
endpackage

// File: rtl/id_ex_hazard.sv
// Load-use hazard detect: a valid load in EX whose destination is read by the
// instruction currently in ID. x0 is never a hazard.
module id_ex_hazard
   import id_ex_pkg::*;
(
   input  logic       ex_valid,
   input  logic       ex_mem_rd_en,
   input  logic       ex_reg_write,
   input  logic [4:0] ex_rd_add,
   input  logic       id_valid,
   input  logic [4:0] id_rs1_add,
   input  logic [4:0] id_rs2_add,
   output logic       lu
);
   // Both source fields are compared unconditionally; the decoder zeroes unused ones.
   assign lu = ex_valid & ex_mem_rd_en & ex_reg_write & (ex_rd_add != ID_EX_BUBBLE_REG)
             & id_valid & ((ex_rd_add == id_rs1_add) | (ex_rd_add == id_rs2_add));
endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use bubble insertion, branch squash and
// saturating stall/flush counters.
module id_ex_stage
   import id_ex_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  hold_i,
   input  logic                  flush_i,
   input  logic                  ID_valid_i,
   input  logic [DATA_WIDTH-1:0] ID_pc_i,
   input  logic [DATA_WIDTH-1:0] ID_rs1_data_i,
   input  logic [DATA_WIDTH-1:0] ID_rs2_data_i,
   input  logic [4:0]            ID_rd_add_i,
   input  logic [4:0]            ID_rs1_add_i,
   input  logic [4:0]            ID_rs2_add_i,
   input  logic [DATA_WIDTH-1:0] ID_imm_i,
   input  logic                  ID_reg_write_i,
   input  logic                  ID_jump_i,
   input  logic                  ID_branch_i,
   input  logic                  ID_mem_rd_en_i,
   input  logic                  ID_mem_wr_en_i,
   input  logic [1:0]            ID_alu_sel1_i,
   input  logic [1:0]            ID_alu_sel2_i,
   input  logic [1:0]            ID_sel_to_reg_i,
   input  logic [3:0]            ID_alu_op_i,
   input  logic [3:0]            ID_mem_op_i,
   output logic                  EX_valid_o,
   output logic [DATA_WIDTH-1:0] EX_pc_o,
   output logic [DATA_WIDTH-1:0] EX_rs1_data_o,
   output logic [DATA_WIDTH-1:0] EX_rs2_data_o,
   output logic [4:0]            EX_rd_add_o,
   output logic [4:0]            EX_rs1_add_o,
   output logic [4:0]            EX_rs2_add_o,
   output logic [DATA_WIDTH-1:0] EX_imm_o,
   output logic                  EX_reg_write_o,
   output logic                  EX_jump_o,
   output logic                  EX_branch_o,
   output logic                  EX_mem_rd_en_o,
   output logic                  EX_mem_wr_en_o,
   output logic [1:0]            EX_alu_sel1_o,
   output logic [1:0]            EX_alu_sel2_o,
   output logic [1:0]            EX_sel_to_reg_o,
   output logic [3:0]            EX_alu_op_o,
   output logic [3:0]            EX_mem_op_o,
   output logic                  stall_o,
   output logic [CNT_WIDTH-1:0]  stall_cnt_o,
   output logic [CNT_WIDTH-1:0]  flush_cnt_o
);
   logic lu;

   id_ex_hazard u_hazard (
      .ex_valid     (EX_valid_o),
      .ex_mem_rd_en (EX_mem_rd_en_o),
      .ex_reg_write (EX_reg_write_o),
      .ex_rd_add    (EX_rd_add_o),
      .id_valid     (ID_valid_i),
      .id_rs1_add   (ID_rs1_add_i),
      .id_rs2_add   (ID_rs2_add_i),
      .lu           (lu)
   );

   // A wrong-path instruction is squashed instead of stalled.
   assign stall_o = lu & ~flush_i & ~hold_i;

   always_ff @(posedge clk_i) begin
      if (!rst_i && hold_i) begin
         EX_valid_o <= EX_valid_o;
      end else if (rst_i || flush_i || lu) begin
         EX_valid_o      <= 1'b0;
         EX_pc_o         <= '0;
         EX_rs1_data_o   <= '0;
         EX_rs2_data_o   <= '0;
         EX_rd_add_o     <= ID_EX_BUBBLE_REG;
         EX_rs1_add_o    <= ID_EX_BUBBLE_REG;
         EX_rs2_add_o    <= ID_EX_BUBBLE_REG;
         EX_imm_o        <= '0;
         EX_reg_write_o  <= 1'b0;
         EX_jump_o       <= 1'b0;
         EX_branch_o     <= 1'b0;
         EX_mem_rd_en_o  <= 1'b0;
         EX_mem_wr_en_o  <= 1'b0;
         EX_alu_sel1_o   <= ID_EX_BUBBLE_SEL;
         EX_alu_sel2_o   <= ID_EX_BUBBLE_SEL;
         EX_sel_to_reg_o <= ID_EX_BUBBLE_SEL;
         EX_alu_op_o     <= ID_EX_BUBBLE_ALU_OP;
         EX_mem_op_o     <= ID_EX_BUBBLE_MEM_OP;
      end else begin
         EX_valid_o      <= ID_valid_i;
         EX_pc_o         <= ID_pc_i;
         EX_rs1_data_o   <= ID_rs1_data_i;
         EX_rs2_data_o   <= ID_rs2_data_i;
         EX_rd_add_o     <= ID_rd_add_i;
         EX_rs1_add_o    <= ID_rs1_add_i;
         EX_rs2_add_o    <= ID_rs2_add_i;
         EX_imm_o        <= ID_imm_i;
         EX_reg_write_o  <= ID_reg_write_i;
         EX_jump_o       <= ID_jump_i;
         EX_branch_o     <= ID_branch_i;
         EX_mem_rd_en_o  <= ID_mem_rd_en_i;
         EX_mem_wr_en_o  <= ID_mem_wr_en_i;
         EX_alu_sel1_o   <= ID_alu_sel1_i;
         EX_alu_sel2_o   <= ID_alu_sel2_i;
         EX_sel_to_reg_o <= ID_sel_to_reg_i;
         EX_alu_op_o     <= ID_alu_op_i;
         EX_mem_op_o     <= ID_mem_op_i;
      end
   end

   // Counters saturate at all-ones so a long run never reports a small wrapped value.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_o <= '0;
         flush_cnt_o <= '0;
      end else if (!hold_i) begin
         if (flush_i) begin
            if (ID_valid_i && (flush_cnt_o != '1))
               flush_cnt_o <= flush_cnt_o + CNT_WIDTH'(1);
         end else if (lu && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(1);
         end
      end
   end
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a reference model pushes the expected EX
// register/counter state per cycle to a queue, popped after the clock edge.
module tb_id_ex_stage;
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic        reg_write;
      logic        jump;
      logic        branch;
      logic        mem_rd_en;
      logic        mem_wr_en;
      logic [1:0]  alu_sel1;
      logic [1:0]  alu_sel2;
      logic [1:0]  sel_to_reg;
      logic [3:0]  alu_op;
      logic [3:0]  mem_op;
   } stage_t;

   typedef struct packed {
      stage_t      ex;
      logic [15:0] stall_cnt;
      logic [15:0] flush_cnt;
      logic [3:0]  s_stall_cnt;
      logic [3:0]  s_flush_cnt;
   } exp_t;

   localparam logic [3:0] LW_OP = 4'b0010;

   logic clk = 1'b0;
   logic rst = 1'b0, hold = 1'b0, flush = 1'b0;
   stage_t id;

   logic        ex_valid, ex_reg_write, ex_jump, ex_branch, ex_mem_rd_en, ex_mem_wr_en, stall;
   logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]  ex_rd, ex_rs1, ex_rs2;
   logic [1:0]  ex_alu_sel1, ex_alu_sel2, ex_sel_to_reg;
   logic [3:0]  ex_alu_op, ex_mem_op;
   logic [15:0] stall_cnt, flush_cnt;

   logic        s_valid, s_reg_write, s_jump, s_branch, s_mem_rd_en, s_mem_wr_en, s_stall;
   logic [31:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
   logic [4:0]  s_rd, s_rs1, s_rs2;
   logic [1:0]  s_alu_sel1, s_alu_sel2, s_sel_to_reg;
   logic [3:0]  s_alu_op, s_mem_op;
   logic [3:0]  s_stall_cnt, s_flush_cnt;

   stage_t ex_obs, s_obs;
   assign ex_obs = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_rd, ex_rs1, ex_rs2, ex_imm,
                    ex_reg_write, ex_jump, ex_branch, ex_mem_rd_en, ex_mem_wr_en,
                    ex_alu_sel1, ex_alu_sel2, ex_sel_to_reg, ex_alu_op, ex_mem_op};
   assign s_obs  = {s_valid, s_pc, s_rs1_data, s_rs2_data, s_rd, s_rs1, s_rs2, s_imm,
                    s_reg_write, s_jump, s_branch, s_mem_rd_en, s_mem_wr_en,
                    s_alu_sel1, s_alu_sel2, s_sel_to_reg, s_alu_op, s_mem_op};

   always #5 clk = ~clk;

   id_ex_stage #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
      .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush),
      .ID_valid_i(id.valid), .ID_pc_i(id.pc), .ID_rs1_data_i(id.rs1_data),
      .ID_rs2_data_i(id.rs2_data), .ID_rd_add_i(id.rd), .ID_rs1_add_i(id.rs1),
      .ID_rs2_add_i(id.rs2), .ID_imm_i(id.imm), .ID_reg_write_i(id.reg_write),
      .ID_jump_i(id.jump), .ID_branch_i(id.branch), .ID_mem_rd_en_i(id.mem_rd_en),
      .ID_mem_wr_en_i(id.mem_wr_en), .ID_alu_sel1_i(id.alu_sel1), .ID_alu_sel2_i(id.alu_sel2),
      .ID_sel_to_reg_i(id.sel_to_reg), .ID_alu_op_i(id.alu_op), .ID_mem_op_i(id.mem_op),
      .EX_valid_o(ex_valid), .EX_pc_o(ex_pc), .EX_rs1_data_o(ex_rs1_data),
      .EX_rs2_data_o(ex_rs2_data), .EX_rd_add_o(ex_rd), .EX_rs1_add_o(ex_rs1),
      .EX_rs2_add_o(ex_rs2), .EX_imm_o(ex_imm), .EX_reg_write_o(ex_reg_write),
      .EX_jump_o(ex_jump), .EX_branch_o(ex_branch), .EX_mem_rd_en_o(ex_mem_rd_en),
      .EX_mem_wr_en_o(ex_mem_wr_en), .EX_alu_sel1_o(ex_alu_sel1), .EX_alu_sel2_o(ex_alu_sel2),
      .EX_sel_to_reg_o(ex_sel_to_reg), .EX_alu_op_o(ex_alu_op), .EX_mem_op_o(ex_mem_op),
      .stall_o(stall), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
   );

   // Narrow-counter instance so saturation is reachable in a short run.
   id_ex_stage #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut_sat (
      .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush),
      .ID_valid_i(id.valid), .ID_pc_i(id.pc), .ID_rs1_data_i(id.rs1_data),
      .ID_rs2_data_i(id.rs2_data), .ID_rd_add_i(id.rd), .ID_rs1_add_i(id.rs1),
      .ID_rs2_add_i(id.rs2), .ID_imm_i(id.imm), .ID_reg_write_i(id.reg_write),
      .ID_jump_i(id.jump), .ID_branch_i(id.branch), .ID_mem_rd_en_i(id.mem_rd_en),
      .ID_mem_wr_en_i(id.mem_wr_en), .ID_alu_sel1_i(id.alu_sel1), .ID_alu_sel2_i(id.alu_sel2),
      .ID_sel_to_reg_i(id.sel_to_reg), .ID_alu_op_i(id.alu_op), .ID_mem_op_i(id.mem_op),
      .EX_valid_o(s_valid), .EX_pc_o(s_pc), .EX_rs1_data_o(s_rs1_data),
      .EX_rs2_data_o(s_rs2_data), .EX_rd_add_o(s_rd), .EX_rs1_add_o(s_rs1),
      .EX_rs2_add_o(s_rs2), .EX_imm_o(s_imm), .EX_reg_write_o(s_reg_write),
      .EX_jump_o(s_jump), .EX_branch_o(s_branch), .EX_mem_rd_en_o(s_mem_rd_en),
      .EX_mem_wr_en_o(s_mem_wr_en), .EX_alu_sel1_o(s_alu_sel1), .EX_alu_sel2_o(s_alu_sel2),
      .EX_sel_to_reg_o(s_sel_to_reg), .EX_alu_op_o(s_alu_op), .EX_mem_op_o(s_mem_op),
      .stall_o(s_stall), .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
   );

   int   total = 0;
   int   bad = 0;
   exp_t sb_q[$];
   exp_t m;

   task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, act, exp);
      end
   endtask

   function automatic stage_t bubble();
      stage_t b = '0;
      b.mem_op = LW_OP;
      return b;
   endfunction

   function automatic stage_t instr(input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2, input logic load);
      stage_t i = '0;
      i.valid     = 1'b1;
      i.pc        = 32'h100 + 32'(rd) * 4;
      i.rs1_data  = 32'hA000_0000 | 32'(rs1);
      i.rs2_data  = 32'hB000_0000 | 32'(rs2);
      i.rd        = rd;
      i.rs1       = rs1;
      i.rs2       = load ? 5'd0 : rs2;
      i.imm       = load ? 32'h10 : 32'h0;
      i.reg_write = 1'b1;
      i.mem_rd_en = load;
      i.alu_sel2  = load ? 2'd1 : 2'd0;
      i.sel_to_reg = load ? 2'd1 : 2'd0;
      i.mem_op    = load ? LW_OP : 4'd0;
      return i;
   endfunction

   function automatic stage_t rand_instr();
      logic [191:0] raw = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      stage_t r = stage_t'(raw[$bits(stage_t)-1:0]);
      r.valid = ($urandom_range(0, 3) != 0);
      r.rd    = 5'($urandom_range(0, 7));
      r.rs1   = 5'($urandom_range(0, 7));
      r.rs2   = 5'($urandom_range(0, 7));
      return r;
   endfunction

   function automatic logic model_lu(input stage_t ex, input stage_t in);
      return ex.valid && ex.mem_rd_en && ex.reg_write && (ex.rd != 5'd0) && in.valid &&
             ((ex.rd == in.rs1) || (ex.rd == in.rs2));
   endfunction

   // One cycle: drive at negedge, check stall_o, push expected, pop/compare after the edge.
   task automatic step(input stage_t in, input logic h, input logic f, input logic r);
      logic lu;
      exp_t e, got;
      @(negedge clk);
      id = in; hold = h; flush = f; rst = r;
      #1;
      lu = model_lu(m.ex, in);
      if (!r) begin
         chk("stall", 256'(stall), 256'(lu && !f && !h));
         chk("s_stall", 256'(s_stall), 256'(lu && !f && !h));
      end
      e = m;
      if (r) begin
         e.ex = bubble(); e.stall_cnt = '0; e.flush_cnt = '0;
         e.s_stall_cnt = '0; e.s_flush_cnt = '0;
      end else if (!h) begin
         if (f) begin
            e.ex = bubble();
            if (in.valid) begin
               if (e.flush_cnt != 16'hFFFF) e.flush_cnt++;
               if (e.s_flush_cnt != 4'hF) e.s_flush_cnt++;
            end
         end else if (lu) begin
            e.ex = bubble();
            if (e.stall_cnt != 16'hFFFF) e.stall_cnt++;
            if (e.s_stall_cnt != 4'hF) e.s_stall_cnt++;
         end else begin
            e.ex = in;
         end
      end
      m = e;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      chk("ex", 256'(ex_obs), 256'(got.ex));
      chk("stall_cnt", 256'(stall_cnt), 256'(got.stall_cnt));
      chk("flush_cnt", 256'(flush_cnt), 256'(got.flush_cnt));
      chk("s_ex", 256'(s_obs), 256'(got.ex));
      chk("s_stall_cnt", 256'(s_stall_cnt), 256'(got.s_stall_cnt));
      chk("s_flush_cnt", 256'(s_flush_cnt), 256'(got.s_flush_cnt));
   endtask

   initial begin
      stage_t add3, lw5, add6, lw0, add0, nop;
      m = '0;
      id = '0;
      nop = '0;
      add3 = instr(5'd3, 5'd1, 5'd2, 1'b0);
      lw5  = instr(5'd5, 5'd1, 5'd0, 1'b1);
      add6 = instr(5'd6, 5'd5, 5'd1, 1'b0);
      lw0  = instr(5'd0, 5'd2, 5'd0, 1'b1);
      add0 = instr(5'd7, 5'd0, 5'd4, 1'b0);

      // Reset: two cycles, EX holds bubble and counters clear.
      step(add3, 1'b0, 1'b0, 1'b1);
      step(add3, 1'b0, 1'b0, 1'b1);
      chk("reset_valid", 256'(ex_valid), 256'(0));
      chk("reset_stall", 256'(stall), 256'(0));

      // Plain ALU op passes through with 1-cycle latency.
      step(add3, 1'b0, 1'b0, 1'b0);
      chk("add_rd", 256'(ex_rd), 256'(3));

      // Load-use: one bubble, then the dependent op enters.
      step(lw5, 1'b0, 1'b0, 1'b0);
      step(add6, 1'b0, 1'b0, 1'b0);
      chk("lu_cnt", 256'(stall_cnt), 256'(1));
      step(add6, 1'b0, 1'b0, 1'b0);
      chk("lu_enter", 256'(ex_rd), 256'(6));

      // Load to x0 never stalls.
      step(lw0, 1'b0, 1'b0, 1'b0);
      step(add0, 1'b0, 1'b0, 1'b0);
      chk("x0_rd", 256'(ex_rd), 256'(7));

      // Flush beats load-use.
      step(lw5, 1'b0, 1'b0, 1'b0);
      step(add6, 1'b0, 1'b1, 1'b0);
      chk("flush_cnt1", 256'(flush_cnt), 256'(1));
      chk("flush_stall_cnt", 256'(stall_cnt), 256'(1));

      // Hold freezes everything, including pending hazard and flush.
      step(lw5, 1'b0, 1'b0, 1'b0);
      step(add6, 1'b1, 1'b0, 1'b0);
      step(rand_instr(), 1'b1, 1'b1, 1'b0);
      step(rand_instr(), 1'b1, 1'b0, 1'b0);
      chk("hold_rd", 256'(ex_rd), 256'(5));
      step(add6, 1'b0, 1'b0, 1'b0);
      step(add6, 1'b0, 1'b0, 1'b0);

      // Invalid instruction under flush does not count.
      step(nop, 1'b0, 1'b1, 1'b0);

      // Random mix.
      for (int i = 0; i < 60; i++)
         step(rand_instr(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 1'b0);

      // Drive stalls past the 4-bit counter limit, with a held hazard at the end.
      for (int i = 0; i < 20; i++) begin
         step(lw5, 1'b0, 1'b0, 1'b0);
         step(add6, 1'b0, 1'b0, 1'b0);
         step(add6, 1'b0, 1'b0, 1'b0);
      end
      chk("sat_stall", 256'(s_stall_cnt), 256'(15));
      step(lw5, 1'b0, 1'b0, 1'b0);
      step(add6, 1'b1, 1'b0, 1'b0);
      step(add6, 1'b0, 1'b0, 1'b0);
      chk("sat_hold", 256'(s_stall_cnt), 256'(15));

      // Reset mid-stall.
      step(lw5, 1'b0, 1'b0, 1'b0);
      step(add6, 1'b0, 1'b0, 1'b1);
      step(add6, 1'b0, 1'b0, 1'b0);
      chk("post_rst_rd", 256'(ex_rd), 256'(6));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
